// File: rtl/freq_meter_if.sv
// Measurement bus for freq_meter: enable and raw signal in, result and strobe out.
// The block that hosts the meter drives EN/SIG_IN (master); the meter itself is the slave.
interface freq_meter_if #(
  parameter int N = 32
);
  logic         EN;
  logic         SIG_IN;
  logic [N-1:0] FREQ_OUT;
  logic         OVF_OUT;
  logic         VALID;

  modport master (
    output EN,
    output SIG_IN,
    input  FREQ_OUT,
    input  OVF_OUT,
    input  VALID
  );

  modport slave (
    input  EN,
    input  SIG_IN,
    output FREQ_OUT,
    output OVF_OUT,
    output VALID
  );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of SIG_IN over
// back-to-back windows of G = CLK_Freq/GATE_Freq clock cycles and reports the
// count (saturating at 2^N-1, with a sticky overflow flag) once per window.
module freq_meter #(
  parameter int CLK_Freq  = 50000000,
  parameter int GATE_Freq = 1,
  parameter int N         = 32,
  parameter int W         = 26
) (
  input  logic   CLK_50M,
  input  logic   nCLR,
  freq_meter_if.slave bus
);

  localparam int           G        = CLK_Freq / GATE_Freq;
  localparam logic [W-1:0] G_LAST   = W'(G - 1);
  localparam logic [N-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t       state_q;
  logic         s1_q, s2_q, s3_q;
  logic [W-1:0] gate_q;
  logic [N-1:0] edge_q;
  logic         sat_q;
  logic [N-1:0] freq_q;
  logic         ovf_q;
  logic         valid_q;

  logic         edge_det;
  logic         at_max;
  logic         last_cycle;
  logic [N-1:0] edge_d;
  logic         sat_d;

  // Synchronize SIG_IN and keep one cycle of history; runs in every state so a
  // level that is already high at enable time is never seen as a fresh edge.
  always_ff @(posedge CLK_50M or negedge nCLR) begin
    if (!nCLR) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.SIG_IN;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Edge detect and the saturating edge count / sticky overflow this cycle would produce.
  always_comb begin
    edge_det   = s2_q & ~s3_q;
    at_max     = (edge_q == CNT_MAX);
    last_cycle = (gate_q == G_LAST);
    edge_d     = edge_q;
    sat_d      = sat_q;
    if (edge_det) begin
      if (at_max) begin
        sat_d = 1'b1;
      end else begin
        edge_d = edge_q + N'(1);
      end
    end
  end

  // Gate FSM, counters and registered results. The window-close cycle always
  // completes, even if EN drops on that same edge.
  always_ff @(posedge CLK_50M or negedge nCLR) begin
    if (!nCLR) begin
      state_q <= IDLE;
      gate_q  <= '0;
      edge_q  <= '0;
      sat_q   <= 1'b0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.EN) begin
            state_q <= COUNT;
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
          end
        end
        COUNT: begin
          if (last_cycle) begin
            freq_q  <= edge_d;
            ovf_q   <= sat_d;
            valid_q <= 1'b1;
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            if (!bus.EN) begin
              state_q <= IDLE;
            end
          end else if (!bus.EN) begin
            // Partial window is dropped; results keep their last value.
            state_q <= IDLE;
          end else begin
            gate_q <= gate_q + W'(1);
            edge_q <= edge_d;
            sat_q  <= sat_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.FREQ_OUT = freq_q;
  assign bus.OVF_OUT  = ovf_q;
  assign bus.VALID    = valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: two instances (N=32 and N=4) share one
// stimulus stream; a reference model predicts each window result from the
// list of SIG_IN rise times and the window boundaries.
module tb_freq_meter;

  localparam int G = 1000;

  logic clk  = 1'b0;
  logic nclr = 1'b0;
  logic en   = 1'b0;
  logic sig  = 1'b0;

  always #5 clk = ~clk;

  freq_meter_if #(.N(32)) ifa ();
  freq_meter_if #(.N(4))  ifb ();

  assign ifa.EN     = en;
  assign ifa.SIG_IN = sig;
  assign ifb.EN     = en;
  assign ifb.SIG_IN = sig;

  freq_meter #(.CLK_Freq(1000), .GATE_Freq(1), .N(32), .W(10)) dut_a (
    .CLK_50M(clk),
    .nCLR   (nclr),
    .bus    (ifa)
  );

  freq_meter #(.CLK_Freq(1000), .GATE_Freq(1), .N(4), .W(10)) dut_b (
    .CLK_50M(clk),
    .nCLR   (nclr),
    .bus    (ifb)
  );

  typedef struct {
    int     t;
    longint f;
    bit     o;
  } exp_t;

  exp_t   qa[$];
  exp_t   qb[$];
  int     rises[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc    = 0;

  // Stimulus shaping: 0 = low, 1 = periodic, 2 = high, 3 = single 4-cycle pulse.
  int     sig_mode = 0;
  int     sig_hi   = 5;
  int     sig_lo   = 5;
  int     ph       = 0;
  int     pulse_at = -100;

  // Model window state and last results seen on the DUTs.
  bit     m_act = 1'b0;
  int     m_k   = 0;
  longint last_a = -1;
  longint last_b = -1;
  longint last_oa = -1;
  longint last_ob = -1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  // An edge rising between posedges t and t+1 passes two sync flops and is
  // counted on posedge t+3; a window started at k counts posedges k+1..k+G.
  task automatic close_window();
    int   c;
    exp_t e;
    c = 0;
    foreach (rises[i]) begin
      if (rises[i] + 3 > m_k && rises[i] + 3 <= cyc) c++;
    end
    e.t = cyc; e.f = c; e.o = 1'b0;
    qa.push_back(e);
    e.f = (c > 15) ? 15 : c;
    e.o = (c > 15);
    qb.push_back(e);
  endtask

  // Reference model: window boundaries driven by the sampled EN and reset.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!nclr) begin
      m_act = 1'b0;
      rises.delete();
      qa.delete();
      qb.delete();
    end else if (!m_act) begin
      if (en) begin
        m_act = 1'b1;
        m_k   = cyc;
      end
    end else if (cyc == m_k + G) begin
      close_window();
      if (en) m_k = cyc;
      else    m_act = 1'b0;
    end else if (!en) begin
      m_act = 1'b0;
    end
  end

  // SIG_IN generator, changes only on the falling edge; records every rise.
  initial forever begin
    logic nv;
    @(negedge clk);
    nv = sig;
    case (sig_mode)
      1: begin
        ph++;
        if (sig && ph >= sig_hi) begin
          nv = 1'b0; ph = 0;
        end else if (!sig && ph >= sig_lo) begin
          nv = 1'b1; ph = 0;
        end
      end
      2: nv = 1'b1;
      3: nv = (cyc >= pulse_at) && (cyc < pulse_at + 4);
      default: nv = 1'b0;
    endcase
    if (nv && !sig) rises.push_back(cyc);
    sig = nv;
  end

  // Monitor: every VALID must match the head of the scoreboard, and every
  // predicted close must see a VALID on exactly that cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (nclr) begin
      if (ifa.VALID || qa.size() > 0) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_valid", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_valid_cycle", ifa.VALID ? cyc : -1, e.t);
          if (ifa.VALID) begin
            chk("a_freq", ifa.FREQ_OUT, e.f);
            chk("a_ovf", ifa.OVF_OUT, e.o);
            last_a  = ifa.FREQ_OUT;
            last_oa = ifa.OVF_OUT;
          end
        end
      end
      if (ifb.VALID || qb.size() > 0) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_valid", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b_valid_cycle", ifb.VALID ? cyc : -1, e.t);
          if (ifb.VALID) begin
            chk("b_freq", ifb.FREQ_OUT, e.f);
            chk("b_ovf", ifb.OVF_OUT, e.o);
            last_b  = ifb.FREQ_OUT;
            last_ob = ifb.OVF_OUT;
          end
        end
      end
    end
  end

  task automatic wait_until(input int t);
    for (int i = 0; i < 3 * G && cyc < t; i++) @(negedge clk);
    if (cyc != t) chk("wait_timeout", cyc, t);
  endtask

  initial begin
    int k0, k1, k2;
    longint hold_a;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_freq_a", ifa.FREQ_OUT, 0);
    chk("rst_ovf_a", ifa.OVF_OUT, 0);
    chk("rst_valid_a", ifa.VALID, 0);
    chk("rst_freq_b", ifb.FREQ_OUT, 0);
    nclr = 1'b1;

    // Period 10, 50% duty: 100 per window; N=4 saturates at 15 with overflow
    sig_hi = 5; sig_lo = 5; sig_mode = 1;
    repeat (7) @(negedge clk);
    en = 1'b1;
    repeat (3 * G + 5) @(negedge clk);
    chk("p10_freq_a", last_a, 100);
    chk("p10_ovf_a", last_oa, 0);
    chk("p10_freq_b", last_b, 15);
    chk("p10_ovf_b", last_ob, 1);

    // Period 100: 10 per window, no overflow on N=4
    sig_hi = 50; sig_lo = 50;
    repeat (3 * G + 5) @(negedge clk);
    chk("p100_freq_b", last_b, 10);
    chk("p100_ovf_b", last_ob, 0);
    chk("p100_freq_a", last_a, 10);

    // SIG_IN already high before EN rises: no false edge
    en = 1'b0; sig_mode = 2;
    repeat (20) @(negedge clk);
    en = 1'b1;
    repeat (G + 5) @(negedge clk);
    chk("high_first_freq_a", last_a, 0);

    // Drop EN mid-window, re-enable 20 cycles later: results hold, no VALID
    sig_hi = $urandom_range(2, 20); sig_lo = $urandom_range(2, 20); sig_mode = 1;
    wait_until(m_k + 499);
    hold_a = ifa.FREQ_OUT;
    en = 1'b0;
    repeat (20) @(negedge clk);
    chk("en_drop_hold_a", ifa.FREQ_OUT, hold_a);
    en = 1'b1;
    repeat (G + 5) @(negedge clk);

    // Edge detected on the closing cycle belongs to the closing window
    sig_mode = 3; pulse_at = -100;
    k0 = m_k;
    k1 = k0 + G;
    wait_until(k1 + G - 10);
    pulse_at = k1 + G - 3;
    wait_until(k1 + G + 2);
    chk("close_edge_in_window", last_a, 1);
    k2 = k1 + G;
    pulse_at = k2 + G - 2;
    wait_until(k2 + G + 2);
    chk("late_edge_not_in_window", last_a, 0);
    wait_until(k2 + 2 * G + 2);
    chk("late_edge_next_window", last_a, 1);

    // Asynchronous reset mid-window clears outputs without a clock edge
    wait_until(m_k + 300);
    @(posedge clk);
    #2 nclr = 1'b0;
    #1;
    chk("async_rst_freq_a", ifa.FREQ_OUT, 0);
    chk("async_rst_ovf_a", ifa.OVF_OUT, 0);
    chk("async_rst_valid_a", ifa.VALID, 0);
    chk("async_rst_freq_b", ifb.FREQ_OUT, 0);
    chk("async_rst_ovf_b", ifb.OVF_OUT, 0);
    repeat (3) @(negedge clk);
    nclr = 1'b1;

    // Random periods and duty cycles after reset
    sig_mode = 1;
    for (int i = 0; i < 4; i++) begin
      sig_hi = $urandom_range(2, 30);
      sig_lo = $urandom_range(2, 30);
      repeat (G - 7 + $urandom_range(0, 20)) @(negedge clk);
    end
    repeat (G + 10) @(negedge clk);

    chk("scoreboard_drained", qa.size() + qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
